cache_arbiter: RTL and testbench

//   Arbitrates I-cache and D-cache line misses onto the single physical-memory port.

---
 rtl/cache_arbiter.sv | 91 +++++++++
 tb/tb_cache_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache line misses onto one physical-memory port.
// D-side has priority; a starvation counter forces an I grant after STARVE_LIMIT D grants.
module cache_arbiter #(
  parameter int LINE_W       = 256,
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [1:0]        dbg_state
);

  // Handshake: a cache holds its request until its resp pulse and drops it the
  // next cycle; memory holds off until a strobe is seen and answers with a
  // one-cycle pmem_resp, after which the strobe drops on the following cycle.
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RECOVER} state_t;

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             d_req;
  logic             d_wins;

  assign d_req  = d_pmem_read | d_pmem_write;
  assign d_wins = d_req && (!i_pmem_read || (starve_cnt < CNT_W'(STARVE_LIMIT)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_wins) begin
            state        <= SERVE_D;
            pmem_read    <= d_pmem_read;
            pmem_write   <= d_pmem_write;
            pmem_address <= d_pmem_address;
            pmem_wdata   <= d_pmem_wdata;
            // D only wins over a waiting I while below the limit, so +1 cannot overshoot.
            starve_cnt   <= i_pmem_read ? starve_cnt + 1'b1 : '0;
          end else if (i_pmem_read) begin
            state        <= SERVE_I;
            pmem_read    <= 1'b1;
            pmem_write   <= 1'b0;
            pmem_address <= i_pmem_address;
            pmem_wdata   <= '0;
            starve_cnt   <= '0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            state      <= RECOVER;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end
        end
        RECOVER: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign i_pmem_resp  = !rst && (state == SERVE_I) && pmem_resp;
  assign d_pmem_resp  = !rst && (state == SERVE_D) && pmem_resp;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;
  assign dbg_state    = state;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios with literal expectations, then
// randomized cache/memory agents checked every cycle against a transaction-level model.
module tb_cache_arbiter;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  localparam int LIMIT  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_pmem_read = 1'b0;
  logic [ADDR_W-1:0] i_pmem_address = '0;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read = 1'b0;
  logic              d_pmem_write = 1'b0;
  logic [ADDR_W-1:0] d_pmem_address = '0;
  logic [LINE_W-1:0] d_pmem_wdata = '0;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata = '0;
  logic              pmem_resp = 1'b0;
  logic [1:0]        dbg_state;

  cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [ADDR_W-1:0] exp_q[$];

  // Transaction-level model: one outstanding line transfer plus a cooldown.
  bit                m_active;
  bit                m_is_i;
  bit                m_write;
  int                m_cool;
  int                m_cnt;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata;

  bit prev_strobe = 1'b0;
  bit saw_i_resp  = 1'b0;
  bit saw_d_resp  = 1'b0;
  bit saw_strobe  = 1'b0;
  bit mem_busy    = 1'b0;
  int mem_lat     = 0;

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int k = 0; k < LINE_W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Advance the model across a clock edge using the inputs of the cycle just ended.
  task automatic model_step();
    bit d_req;
    d_req = d_pmem_read || d_pmem_write;
    if (rst) begin
      m_active = 0; m_cool = 0; m_cnt = 0; m_write = 0;
      m_addr = '0; m_wdata = '0;
    end else if (m_active) begin
      if (pmem_resp) begin m_active = 0; m_cool = 1; end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (d_req && (!i_pmem_read || m_cnt < LIMIT)) begin
      m_active = 1; m_is_i = 0; m_write = d_pmem_write;
      m_addr = d_pmem_address; m_wdata = d_pmem_wdata;
      m_cnt = i_pmem_read ? ((m_cnt < LIMIT) ? m_cnt + 1 : LIMIT) : 0;
      exp_q.push_back(m_addr);
    end else if (i_pmem_read) begin
      m_active = 1; m_is_i = 1; m_write = 0;
      m_addr = i_pmem_address; m_wdata = '0; m_cnt = 0;
      exp_q.push_back(m_addr);
    end
  endtask

  task automatic compare();
    bit strobe;
    chk("pmem_read", pmem_read, m_active && !m_write);
    chk("pmem_write", pmem_write, m_active && m_write);
    chk("pmem_address", pmem_address, m_addr);
    chk("pmem_wdata", pmem_wdata, m_wdata);
    chk("i_pmem_resp", i_pmem_resp, m_active && m_is_i && pmem_resp && !rst);
    chk("d_pmem_resp", d_pmem_resp, m_active && !m_is_i && pmem_resp && !rst);
    chk("i_pmem_rdata", i_pmem_rdata, pmem_rdata);
    chk("d_pmem_rdata", d_pmem_rdata, pmem_rdata);
    strobe = pmem_read || pmem_write;
    if (strobe && !prev_strobe) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL grant_order: strobe for %0h with no expected grant", pmem_address);
      end else begin
        chk("grant_order", pmem_address, exp_q.pop_front());
      end
    end
    prev_strobe = strobe;
  endtask

  task automatic observe();
    saw_i_resp = i_pmem_resp;
    saw_d_resp = d_pmem_resp;
    saw_strobe = pmem_read || pmem_write;
    if (saw_strobe && !mem_busy) begin
      mem_busy = 1;
      mem_lat  = $urandom_range(0, 3);
    end
  endtask

  task automatic cycle_start();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cycle_end();
    @(negedge clk);
    compare();
    observe();
  endtask

  task automatic idle_cycle();
    cycle_start();
    cycle_end();
  endtask

  // ---------------- random drivers ----------------
  task automatic drive_random();
    if (rst) rst = 1'b0;
    else rst = ($urandom_range(0, 249) == 0);
    pmem_rdata = rand_line();
    if (pmem_resp) begin
      pmem_resp = 1'b0; mem_busy = 0;
    end else if (mem_busy) begin
      if (mem_lat == 0) pmem_resp = 1'b1;
      else mem_lat--;
    end else if (!saw_strobe && $urandom_range(0, 19) == 0) begin
      pmem_resp = 1'b1;
    end
    if (rst || saw_i_resp) begin
      i_pmem_read = 1'b0;
    end else if (i_pmem_read) begin
      if (!(m_active && m_is_i) && $urandom_range(0, 39) == 0) i_pmem_read = 1'b0;
    end else if ($urandom_range(0, 3) == 0) begin
      i_pmem_read    = 1'b1;
      i_pmem_address = $urandom & 32'hFFFF_FFE0;
    end
    if (rst || saw_d_resp) begin
      d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    end else if (d_pmem_read || d_pmem_write) begin
      if (!(m_active && !m_is_i) && $urandom_range(0, 39) == 0) begin
        d_pmem_read = 1'b0; d_pmem_write = 1'b0;
      end
    end else if ($urandom_range(0, 2) == 0) begin
      d_pmem_write   = ($urandom_range(0, 1) == 1);
      d_pmem_read    = !d_pmem_write;
      d_pmem_address = $urandom & 32'hFFFF_FFE0;
      d_pmem_wdata   = rand_line();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [LINE_W-1:0] line_a;
    logic [LINE_W-1:0] wb_line;
    bit served_i;
    int w;

    // Reset
    idle_cycle();
    idle_cycle();
    chk("reset_pmem_read", pmem_read, 1'b0);
    chk("reset_pmem_write", pmem_write, 1'b0);
    chk("reset_pmem_address", pmem_address, 32'h0);
    chk("reset_pmem_wdata", pmem_wdata, '0);
    chk("reset_state_idle", dbg_state, 2'd0);
    cycle_start(); rst = 1'b0; cycle_end();

    // Lone I read of 0x100
    cycle_start(); i_pmem_read = 1'b1; i_pmem_address = 32'h100; cycle_end();
    idle_cycle();
    chk("lone_i_strobe", pmem_read, 1'b1);
    chk("lone_i_addr", pmem_address, 32'h100);
    line_a = rand_line();
    cycle_start(); pmem_resp = 1'b1; pmem_rdata = line_a; cycle_end();
    chk("lone_i_resp", i_pmem_resp, 1'b1);
    chk("lone_i_no_d_resp", d_pmem_resp, 1'b0);
    chk("lone_i_rdata", i_pmem_rdata, line_a);
    cycle_start(); pmem_resp = 1'b0; i_pmem_read = 1'b0; cycle_end();
    chk("lone_i_strobe_drop", pmem_read, 1'b0);
    idle_cycle();

    // Lone D write-back of 0x2A0
    wb_line = {8{32'hA5A5_A5A5}};
    cycle_start(); d_pmem_write = 1'b1; d_pmem_address = 32'h2A0; d_pmem_wdata = wb_line; cycle_end();
    idle_cycle();
    chk("lone_d_write", pmem_write, 1'b1);
    chk("lone_d_no_read", pmem_read, 1'b0);
    chk("lone_d_addr", pmem_address, 32'h2A0);
    chk("lone_d_wdata", pmem_wdata, wb_line);
    cycle_start(); pmem_resp = 1'b1; cycle_end();
    chk("lone_d_resp", d_pmem_resp, 1'b1);
    chk("lone_d_no_i_resp", i_pmem_resp, 1'b0);
    cycle_start(); pmem_resp = 1'b0; d_pmem_write = 1'b0; cycle_end();
    idle_cycle();

    // Simultaneous I and D with counter at zero: D first, I strobe 3 cycles after D resp
    cycle_start();
    i_pmem_read = 1'b1; i_pmem_address = 32'h400;
    d_pmem_read = 1'b1; d_pmem_address = 32'h800;
    cycle_end();
    idle_cycle();
    chk("both_d_first", pmem_address, 32'h800);
    chk("both_model_cnt", m_cnt, 1);
    cycle_start(); pmem_resp = 1'b1; cycle_end();
    chk("both_d_resp", d_pmem_resp, 1'b1);
    chk("both_no_i_resp", i_pmem_resp, 1'b0);
    cycle_start(); pmem_resp = 1'b0; d_pmem_read = 1'b0; cycle_end();
    chk("both_gap1", pmem_read, 1'b0);
    idle_cycle();
    chk("both_gap2", pmem_read, 1'b0);
    idle_cycle();
    chk("both_i_at_m3", pmem_read, 1'b1);
    chk("both_i_addr", pmem_address, 32'h400);
    cycle_start(); pmem_resp = 1'b1; cycle_end();
    chk("both_i_resp", i_pmem_resp, 1'b1);
    cycle_start(); pmem_resp = 1'b0; i_pmem_read = 1'b0; cycle_end();
    idle_cycle();

    // Starvation: I held, D re-requests continuously -> D,D,D,D,I
    cycle_start();
    i_pmem_read = 1'b1; i_pmem_address = 32'h1000;
    d_pmem_read = 1'b1; d_pmem_address = 32'h2000;
    cycle_end();
    for (int g = 0; g < 5; g++) begin
      w = 0;
      while (!(pmem_read || pmem_write) && w < 10) begin idle_cycle(); w++; end
      if (w >= 10) begin
        n_checks++; n_fail++;
        $display("FAIL starve_timeout: no grant %0d within 10 cycles", g);
        break;
      end
      served_i = (pmem_address == 32'h1000);
      chk($sformatf("starve_grant%0d_is_i", g), served_i, g == 4);
      if (g == 3) chk("starve_cnt_saturated", m_cnt, LIMIT);
      cycle_start(); pmem_resp = 1'b1; cycle_end();
      cycle_start();
      pmem_resp = 1'b0;
      if (served_i) i_pmem_read = 1'b0; else d_pmem_read = 1'b0;
      cycle_end();
      cycle_start();
      if (g < 4) begin d_pmem_read = 1'b1; d_pmem_address = 32'h2000 + (g + 1) * 32; end
      else d_pmem_read = 1'b0;
      cycle_end();
    end
    chk("starve_cnt_cleared", m_cnt, 0);
    idle_cycle();
    idle_cycle();

    // Reset while D awaits its response; late response must be ignored
    cycle_start(); d_pmem_read = 1'b1; d_pmem_address = 32'h3C0; cycle_end();
    idle_cycle();
    chk("rst_mid_strobe", pmem_read, 1'b1);
    cycle_start(); rst = 1'b1; cycle_end();
    cycle_start(); rst = 1'b0; d_pmem_read = 1'b0; cycle_end();
    chk("rst_mid_strobe_low", pmem_read, 1'b0);
    chk("rst_mid_addr_zero", pmem_address, 32'h0);
    cycle_start(); pmem_resp = 1'b1; cycle_end();
    chk("rst_late_no_d_resp", d_pmem_resp, 1'b0);
    chk("rst_late_no_i_resp", i_pmem_resp, 1'b0);
    cycle_start(); pmem_resp = 1'b0; cycle_end();
    chk("rst_late_still_idle", pmem_read, 1'b0);

    // Stray responses in IDLE and RECOVER
    cycle_start(); pmem_resp = 1'b1; cycle_end();
    chk("stray_idle_i", i_pmem_resp, 1'b0);
    chk("stray_idle_d", d_pmem_resp, 1'b0);
    cycle_start(); pmem_resp = 1'b0; i_pmem_read = 1'b1; i_pmem_address = 32'h140; cycle_end();
    idle_cycle();
    chk("stray_then_grant", pmem_read, 1'b1);
    chk("stray_then_addr", pmem_address, 32'h140);
    cycle_start(); pmem_resp = 1'b1; cycle_end();
    cycle_start(); i_pmem_read = 1'b0; cycle_end();
    chk("stray_recover_i", i_pmem_resp, 1'b0);
    chk("stray_recover_strobe", pmem_read, 1'b0);
    cycle_start(); pmem_resp = 1'b0; cycle_end();
    idle_cycle();
    chk("stray_recover_idle", pmem_read, 1'b0);

    // Randomized traffic against the model
    mem_busy = 0;
    for (int c = 0; c < 4000; c++) begin
      cycle_start();
      drive_random();
      cycle_end();
    end
    chk("exp_q_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
